// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: computes the next PC and owns the IF/ID
// register, with a one-cycle boot, stall/redirect handling and a HALT freeze.
module fetch_ctrl #(
  parameter int PC_W     = 5,
  parameter int INSTR_W  = 32,
  parameter int RESET_PC = 21
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    pc_cur,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    pc_next,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic               ifid_valid,
  output logic               halted,
  output logic [7:0]         fetch_cnt
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  localparam logic [PC_W-1:0] BOOT_PC = PC_W'(RESET_PC);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic               halted_q, halted_d;
  logic [7:0]         fetch_cnt_q, fetch_cnt_d;
  logic               is_halt;

  assign is_halt = (instr_in[INSTR_W-1 -: 6] == 6'b111111);

  always_comb begin
    state_d      = state_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    halted_d     = halted_q;
    fetch_cnt_d  = fetch_cnt_q;
    pc_next      = pc_cur;

    case (state_q)
      S_BOOT: begin
        pc_next      = BOOT_PC;
        ifid_valid_d = 1'b0;
        state_d      = S_RUN;
      end
      S_RUN: begin
        // A redirect squashes whatever is being fetched, even under stall.
        if (redirect) begin
          pc_next      = redirect_pc;
          ifid_valid_d = 1'b0;
        end else if (stall) begin
          pc_next = pc_cur;
        end else begin
          pc_next      = pc_cur + PC_W'(1);
          ifid_pc_d    = pc_cur;
          ifid_instr_d = instr_in;
          ifid_valid_d = 1'b1;
          fetch_cnt_d  = (fetch_cnt_q == 8'hFF) ? fetch_cnt_q : fetch_cnt_q + 8'd1;
          if (is_halt) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
        end
      end
      S_HALT: begin
        pc_next      = pc_cur;
        ifid_valid_d = 1'b0;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      fetch_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= halted_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_valid = ifid_valid_q;
  assign halted     = halted_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: boot, sequential wrap, stall, redirect,
// HALT with reset recovery and fetch counter saturation.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  pc_cur;
  logic [31:0] instr_in;
  logic        stall;
  logic        redirect;
  logic [4:0]  redirect_pc;
  logic [4:0]  pc_next;
  logic [4:0]  ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        halted;
  logic [7:0]  fetch_cnt;

  int vectors = 0;
  int errors  = 0;

  fetch_ctrl #(.PC_W(5), .INSTR_W(32), .RESET_PC(21)) dut (
    .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .instr_in(instr_in),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc_next(pc_next), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
    .ifid_valid(ifid_valid), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_cur = 5'd0; instr_in = 32'd0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 5'd0;
    step(); step();
    vectors++; if (pc_next !== 5'd21) begin errors++; $display("FAIL rst_pc_next: got %0d want 21", pc_next); end
    vectors++; if (ifid_pc !== 5'd0) begin errors++; $display("FAIL rst_ifid_pc: got %0d want 0", ifid_pc); end
    vectors++; if (ifid_instr !== 32'd0) begin errors++; $display("FAIL rst_ifid_instr: got %h want 0", ifid_instr); end
    vectors++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ifid_valid); end
    vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
    vectors++; if (fetch_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", fetch_cnt); end
  endtask

  task automatic test_boot();
    rst_n = 1'b1;
    #1;
    vectors++; if (pc_next !== 5'd21) begin errors++; $display("FAIL boot_pc_next: got %0d want 21", pc_next); end
    step();
    vectors++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b want 0", ifid_valid); end
    pc_cur = 5'd21; instr_in = 32'h0000_1111;
    #1;
    vectors++; if (pc_next !== 5'd22) begin errors++; $display("FAIL boot_run_pc_next: got %0d want 22", pc_next); end
    step();
    vectors++; if (ifid_pc !== 5'd21) begin errors++; $display("FAIL boot_ifid_pc: got %0d want 21", ifid_pc); end
    vectors++; if (ifid_instr !== 32'h0000_1111) begin errors++; $display("FAIL boot_ifid_instr: got %h want 00001111", ifid_instr); end
    vectors++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL boot_first_valid: got %b want 1", ifid_valid); end
    vectors++; if (fetch_cnt !== 8'd1) begin errors++; $display("FAIL boot_cnt: got %0d want 1", fetch_cnt); end
  endtask

  task automatic test_sequential();
    logic [4:0] pcs [3];
    logic [4:0] nxt [3];
    pcs[0] = 5'd30; pcs[1] = 5'd31; pcs[2] = 5'd0;
    nxt[0] = 5'd31; nxt[1] = 5'd0;  nxt[2] = 5'd1;
    for (int i = 0; i < 3; i++) begin
      pc_cur = pcs[i]; instr_in = 32'hA000_0000 + 32'(i);
      #1;
      vectors++; if (pc_next !== nxt[i]) begin errors++; $display("FAIL seq_pc_next[%0d]: got %0d want %0d", i, pc_next, nxt[i]); end
      step();
      vectors++; if (ifid_pc !== pcs[i]) begin errors++; $display("FAIL seq_ifid_pc[%0d]: got %0d want %0d", i, ifid_pc, pcs[i]); end
      vectors++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b want 1", i, ifid_valid); end
      vectors++; if (fetch_cnt !== 8'(2 + i)) begin errors++; $display("FAIL seq_cnt[%0d]: got %0d want %0d", i, fetch_cnt, 2 + i); end
    end
  endtask

  task automatic test_stall();
    pc_cur = 5'd23; instr_in = 32'hB0B0_0023; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (pc_next !== 5'd23) begin errors++; $display("FAIL stall_pc_next[%0d]: got %0d want 23", i, pc_next); end
      step();
      vectors++; if (ifid_pc !== 5'd0) begin errors++; $display("FAIL stall_ifid_pc[%0d]: got %0d want 0", i, ifid_pc); end
      vectors++; if (ifid_instr !== 32'hA000_0002) begin errors++; $display("FAIL stall_instr[%0d]: got %h want a0000002", i, ifid_instr); end
      vectors++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, ifid_valid); end
      vectors++; if (fetch_cnt !== 8'd4) begin errors++; $display("FAIL stall_cnt[%0d]: got %0d want 4", i, fetch_cnt); end
    end
    stall = 1'b0;
    step();
    vectors++; if (ifid_pc !== 5'd23) begin errors++; $display("FAIL stall_resume_pc: got %0d want 23", ifid_pc); end
    vectors++; if (ifid_instr !== 32'hB0B0_0023) begin errors++; $display("FAIL stall_resume_instr: got %h want b0b00023", ifid_instr); end
    vectors++; if (fetch_cnt !== 8'd5) begin errors++; $display("FAIL stall_resume_cnt: got %0d want 5", fetch_cnt); end
  endtask

  task automatic test_redirect();
    pc_cur = 5'd24; instr_in = 32'hC0C0_0024; stall = 1'b1; redirect = 1'b1; redirect_pc = 5'd4;
    #1;
    vectors++; if (pc_next !== 5'd4) begin errors++; $display("FAIL redir_pc_next: got %0d want 4", pc_next); end
    step();
    vectors++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b want 0", ifid_valid); end
    vectors++; if (ifid_pc !== 5'd23) begin errors++; $display("FAIL redir_ifid_pc: got %0d want 23", ifid_pc); end
    vectors++; if (fetch_cnt !== 8'd5) begin errors++; $display("FAIL redir_cnt: got %0d want 5", fetch_cnt); end
    stall = 1'b0; redirect = 1'b0; pc_cur = 5'd4; instr_in = 32'hD0D0_0004;
    step();
    vectors++; if (ifid_pc !== 5'd4) begin errors++; $display("FAIL redir_target_pc: got %0d want 4", ifid_pc); end
    vectors++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL redir_target_valid: got %b want 1", ifid_valid); end
    vectors++; if (fetch_cnt !== 8'd6) begin errors++; $display("FAIL redir_target_cnt: got %0d want 6", fetch_cnt); end
    // HALT opcode arriving on a redirect edge must be squashed, not detected.
    pc_cur = 5'd5; instr_in = 32'hFC00_0000; redirect = 1'b1; redirect_pc = 5'd9;
    step();
    vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL redir_no_halt: got %b want 0", halted); end
    vectors++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL redir_halt_valid: got %b want 0", ifid_valid); end
    vectors++; if (fetch_cnt !== 8'd6) begin errors++; $display("FAIL redir_halt_cnt: got %0d want 6", fetch_cnt); end
    redirect = 1'b0;
  endtask

  task automatic test_halt();
    pc_cur = 5'd9; instr_in = 32'hFC00_0000;
    step();
    vectors++; if (ifid_instr !== 32'hFC00_0000) begin errors++; $display("FAIL halt_instr: got %h want fc000000", ifid_instr); end
    vectors++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL halt_valid: got %b want 1", ifid_valid); end
    vectors++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b want 1", halted); end
    vectors++; if (fetch_cnt !== 8'd7) begin errors++; $display("FAIL halt_cnt: got %0d want 7", fetch_cnt); end
    instr_in = 32'h0000_0000; redirect = 1'b1; redirect_pc = 5'd3;
    #1;
    vectors++; if (pc_next !== 5'd9) begin errors++; $display("FAIL halt_pc_next: got %0d want 9", pc_next); end
    step(); step();
    vectors++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL halt_frozen_valid: got %b want 0", ifid_valid); end
    vectors++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b want 1", halted); end
    vectors++; if (fetch_cnt !== 8'd7) begin errors++; $display("FAIL halt_frozen_cnt: got %0d want 7", fetch_cnt); end
    vectors++; if (ifid_pc !== 5'd9) begin errors++; $display("FAIL halt_frozen_pc: got %0d want 9", ifid_pc); end
    redirect = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (pc_next !== 5'd21) begin errors++; $display("FAIL halt_rst_pc_next: got %0d want 21", pc_next); end
    vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_rst_halted: got %b want 0", halted); end
    vectors++; if (fetch_cnt !== 8'd0) begin errors++; $display("FAIL halt_rst_cnt: got %0d want 0", fetch_cnt); end
    vectors++; if (ifid_instr !== 32'd0) begin errors++; $display("FAIL halt_rst_instr: got %h want 0", ifid_instr); end
    step();
    rst_n = 1'b1;
    #1;
    vectors++; if (pc_next !== 5'd21) begin errors++; $display("FAIL halt_reboot_pc_next: got %0d want 21", pc_next); end
  endtask

  task automatic test_saturation();
    step();
    for (int i = 0; i < 300; i++) begin
      pc_cur = 5'(i); instr_in = 32'(i);
      step();
      if (i == 253) begin
        vectors++; if (fetch_cnt !== 8'd254) begin errors++; $display("FAIL sat_cnt_254: got %0d want 254", fetch_cnt); end
      end
      if (i == 254) begin
        vectors++; if (fetch_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt_255: got %0d want 255", fetch_cnt); end
      end
    end
    vectors++; if (fetch_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt_end: got %0d want 255", fetch_cnt); end
    vectors++; if (ifid_pc !== 5'd11) begin errors++; $display("FAIL sat_ifid_pc: got %0d want 11", ifid_pc); end
    vectors++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL sat_valid: got %b want 1", ifid_valid); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
